// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response mux for five slaves with a built-in default slave.
// Valid transfers to unmapped or disabled ports receive a two-cycle ERROR response.
module ahblite_slave_mux #(
   parameter bit Port0_en = 1'b1,
   parameter bit Port1_en = 1'b1,
   parameter bit Port2_en = 1'b1,
   parameter bit Port3_en = 1'b1,
   parameter bit Port4_en = 1'b1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  HTRANS,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

   logic [4:0]       port_en, en_sel, hrdyout, hresp_s;
   logic [4:0][31:0] hrdata_s;
   logic [4:0]       sel_q, sel_d;
   logic             dflt_req_q, dflt_req_d, none_sel;
   logic             dflt_rdy, dflt_resp;
   state_t           state_q, state_d;

   assign port_en  = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
   assign en_sel   = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & port_en;
   assign none_sel = ~|en_sel;
   assign hrdyout  = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
   assign hresp_s  = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
   assign hrdata_s = {P4_HRDATA, P3_HRDATA, P2_HRDATA, P1_HRDATA, P0_HRDATA};

   // Address phase is only sampled when the current data phase completes.
   always_comb begin
      sel_d      = sel_q;
      dflt_req_d = dflt_req_q;
      if (HREADY) begin
         sel_d      = en_sel;
         dflt_req_d = none_sel & HTRANS[1];
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         sel_q      <= '0;
         dflt_req_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         sel_q      <= sel_d;
         dflt_req_q <= dflt_req_d;
         state_q    <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dflt_rdy  = 1'b1;
      dflt_resp = 1'b0;
      case (state_q)
         IDLE: if (HREADY && dflt_req_d) state_d = ERR1;
         ERR1: begin
            dflt_rdy  = ~dflt_req_q;
            dflt_resp = dflt_req_q;
            state_d   = ERR2;
         end
         ERR2: begin
            dflt_resp = dflt_req_q;
            state_d   = dflt_req_d ? ERR1 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan high to low so the lowest selected index has the last word.
   always_comb begin
      HREADY = dflt_rdy;
      HRESP  = dflt_resp;
      HRDATA = 32'h0;
      for (int i = 4; i >= 0; i--) begin
         if (sel_q[i]) begin
            HREADY = hrdyout[i];
            HRESP  = hresp_s[i];
            HRDATA = hrdata_s[i];
         end
      end
   end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Randomized and directed bench for ahblite_slave_mux, port 4 built disabled;
// a transfer-level model predicts every data-phase response.
module tb_ahblite_slave_mux;

   localparam logic [4:0] EN = 5'b01111;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic [1:0]  HTRANS;
   logic [4:0]  hsel, hro, hrs;
   logic [31:0] hrd [5];
   logic        HREADY, HRESP;
   logic [31:0] HRDATA;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: index of the slave owning the data phase (-1 none) and
   // error cycle count (0 none, 1 first error cycle, 2 second).
   int m_sel = -1;
   int m_err = 0;

   always #5 HCLK = ~HCLK;

   ahblite_slave_mux #(.Port4_en(1'b0)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
      .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
      .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
      .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]),
      .P3_HREADYOUT(hro[3]), .P4_HREADYOUT(hro[4]),
      .P0_HRESP(hrs[0]), .P1_HRESP(hrs[1]), .P2_HRESP(hrs[2]),
      .P3_HRESP(hrs[3]), .P4_HRESP(hrs[4]),
      .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]),
      .P3_HRDATA(hrd[3]), .P4_HRDATA(hrd[4]),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   function automatic int lowest(logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_out(output logic r, output logic rs, output logic [31:0] d);
      if (m_sel >= 0) begin
         r = hro[m_sel]; rs = hrs[m_sel]; d = hrd[m_sel];
      end else if (m_err == 1) begin
         r = 1'b0; rs = 1'b1; d = 32'h0;
      end else if (m_err == 2) begin
         r = 1'b1; rs = 1'b1; d = 32'h0;
      end else begin
         r = 1'b1; rs = 1'b0; d = 32'h0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge HCLK or posedge HRESET) begin : model_upd
      logic r, rs;
      logic [31:0] d;
      int s;
      if (HRESET) begin
         m_sel <= -1;
         m_err <= 0;
      end else begin
         model_out(r, rs, d);
         if (m_err == 1) m_err <= 2;
         else if (r) begin
            s = lowest(hsel & EN);
            m_sel <= s;
            m_err <= (s < 0 && HTRANS[1]) ? 1 : 0;
         end
      end
   end

   always @(negedge HCLK) begin : compare
      logic r, rs;
      logic [31:0] d;
      if (!HRESET) begin
         model_out(r, rs, d);
         chk("model HREADY", {31'h0, HREADY}, {31'h0, r});
         chk("model HRESP", {31'h0, HRESP}, {31'h0, rs});
         chk("model HRDATA", HRDATA, d);
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      @(negedge HCLK);
      #1;
   endtask

   task automatic idle_bus();
      hsel = '0; HTRANS = 2'b00; hro = '1; hrs = '0;
      for (int i = 0; i < 5; i++) hrd[i] = 32'h0;
   endtask

   task automatic chk_rr(input string nm, input logic r, input logic rs);
      chk({nm, " HREADY"}, {31'h0, HREADY}, {31'h0, r});
      chk({nm, " HRESP"}, {31'h0, HRESP}, {31'h0, rs});
   endtask

   initial begin
      idle_bus();
      #2;
      chk_rr("reset", 1'b1, 1'b0);
      chk("reset HRDATA", HRDATA, 32'h0);
      tick(); tick();
      HRESET = 1'b0;

      // zero-wait read from RAMDATA
      tick(); hsel = 5'b00010; HTRANS = 2'b10;
      tick(); idle_bus(); hrd[1] = 32'hDEADBEEF;
      settle();
      chk("p1 read HRDATA", HRDATA, 32'hDEADBEEF);
      chk_rr("p1 read", 1'b1, 1'b0);

      // GPIO wait states while a keyboard access waits on the bus
      tick(); hsel = 5'b00100; HTRANS = 2'b10;
      tick(); hsel = 5'b01000; hro[2] = 1'b0; hrd[2] = 32'hA5A5_0002; hrd[3] = 32'h3333_0003;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("gpio wait HREADY", {31'h0, HREADY}, 32'h0);
         if (k < 2) tick();
      end
      tick(); hro[2] = 1'b1;
      settle();
      chk_rr("gpio done", 1'b1, 1'b0);
      chk("gpio HRDATA", HRDATA, 32'hA5A5_0002);
      tick(); hsel = '0; HTRANS = 2'b00; hro[2] = 1'b0;
      settle();
      chk("kbd HRDATA", HRDATA, 32'h3333_0003);
      chk_rr("kbd", 1'b1, 1'b0);

      // unmapped valid transfer
      tick(); idle_bus(); HTRANS = 2'b10;
      tick(); HTRANS = 2'b00;
      settle(); chk_rr("unmapped err1", 1'b0, 1'b1);
      tick(); settle(); chk_rr("unmapped err2", 1'b1, 1'b1);
      tick(); settle(); chk_rr("unmapped after", 1'b1, 1'b0);

      // unmapped IDLE transfer: plain OKAY
      tick(); settle(); chk_rr("unmapped idle 1", 1'b1, 1'b0);
      tick(); settle(); chk_rr("unmapped idle 2", 1'b1, 1'b0);

      // back-to-back unmapped, second presented during ERR2
      tick(); HTRANS = 2'b10;
      tick(); settle(); chk_rr("b2b a1", 1'b0, 1'b1);
      tick(); settle(); chk_rr("b2b a2", 1'b1, 1'b1);
      tick(); HTRANS = 2'b00;
      settle(); chk_rr("b2b b1", 1'b0, 1'b1);
      tick(); settle(); chk_rr("b2b b2", 1'b1, 1'b1);
      tick(); settle(); chk_rr("b2b end", 1'b1, 1'b0);

      // disabled port 4 errors; reset during ERR1 clears at once
      tick(); hsel = 5'b10000; HTRANS = 2'b10; hrd[4] = 32'h4444_4444;
      tick(); idle_bus();
      settle(); chk_rr("p4 disabled err1", 1'b0, 1'b1);
      HRESET = 1'b1;
      #1;
      chk_rr("reset mid err", 1'b1, 1'b0);
      chk("reset mid err HRDATA", HRDATA, 32'h0);
      tick(); tick(); HRESET = 1'b0;
      tick(); settle(); chk_rr("post reset idle", 1'b1, 1'b0);

      // randomized traffic against the model
      repeat (600) begin
         tick();
         case ($urandom_range(0, 5))
            0:       hsel = 5'($urandom);
            1, 2:    hsel = '0;
            default: hsel = 5'(1 << $urandom_range(0, 4));
         endcase
         HTRANS = 2'($urandom);
         for (int i = 0; i < 5; i++) begin
            hro[i] = ($urandom_range(0, 9) < 7);
            hrs[i] = ($urandom_range(0, 9) == 0);
            hrd[i] = $urandom;
         end
      end
      tick(); idle_bus();
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahblite_slave_mux.md
# ahblite_slave_mux

AHB-Lite data-phase response multiplexer with a built-in default slave. It sits directly downstream of the address decoder. It registers the five decoded `Px_HSEL` lines during the address phase. In the data phase it routes the selected slave's `HRDATA`/`HREADYOUT`/`HRESP` back to the Cortex-M0 master. Valid transfers to unmapped or disabled regions get a two-cycle AHB ERROR response.

## Interface
- `Port0_en`, default 1: RAMCODE port enable. 0 treats the port as unmapped. Must match the decoder setting.
- `Port1_en`, default 1: RAMDATA port enable.
- `Port2_en`, default 1: GPIO port enable.
- `Port3_en`, default 1: Keyboard port enable.
- `Port4_en`, default 1: SEG port enable.

Ports:
- `HCLK`  in  1: bus clock. Single clock domain.
- `HRESET`  in  1: asynchronous, active-high reset.
- `HTRANS`  in  2: master transfer type. Bit 1 set means NONSEQ/SEQ (valid).
- `P0_HSEL`..`P4_HSEL`  in  1 each: address-phase selects from the decoder.
- `P0_HREADYOUT`..`P4_HREADYOUT`  in  1 each: slave ready.
- `P0_HRESP`..`P4_HRESP`  in  1 each: slave response (1 = ERROR).
- `P0_HRDATA`..`P4_HRDATA`  in  32 each: slave read data.
- `HREADY`  out  1: muxed ready to the master and to every slave's `HREADY` input.
- `HRESP`  out  1: muxed response to the master.
- `HRDATA`  out  32: muxed read data to the master.

## Operation
- **Effective selects:** `en_sel[i] = Px_HSEL & Port_i_en`.
- **Unmapped flag:** `none_sel = ~|en_sel`.
- **Address-phase capture:** on a `HCLK` rising edge with `HREADY==1`:
  - `sel_q <= en_sel` (5-bit one-hot or zero).
  - `dflt_req <= none_sel & HTRANS[1]`.
- **Hold:** while `HREADY==0`, `sel_q` and `dflt_req` hold.
- **Multiple selects:** more than one `en_sel` bit set is illegal from the decoder. If it occurs, the lowest index wins in the mux and all bits are still registered.
- **Data-phase mux, slave selected:** `sel_q` nonzero → `HRDATA`/`HREADY`/`HRESP` come from the lowest set index.
- **Data-phase mux, nothing selected, default slave idle:** `sel_q` zero → `HRDATA=32'h0`, `HREADY=1`, `HRESP=0`.
- **Default-slave FSM** (states IDLE, ERR1, ERR2):
  - IDLE: outputs `HREADY=1`, `HRESP=0`. Goes to ERR1 when a captured transfer sets `dflt_req`.
  - ERR1: outputs `HREADY=0`, `HRESP=1`. Always goes to ERR2 next cycle.
  - ERR2: outputs `HREADY=1`, `HRESP=1`. Because `HREADY=1` here, the next address phase is sampled. An unmapped valid transfer goes to ERR1; anything else goes to IDLE.
  - When the FSM is in ERR1/ERR2, `sel_q` is zero, so the FSM outputs drive `HREADY`/`HRESP`. `HRDATA` is 0.
- **IDLE/BUSY transfers** (`HTRANS[1]==0`) to an unmapped address get no error and a zero-wait OKAY.
- **Selected slave with an IDLE transfer:** the slave itself returns OKAY.
- **Reset** (async, any state, including mid-ERR1):
  - `sel_q=0`, `dflt_req=0`, FSM=IDLE.
  - Outputs immediately `HREADY=1`, `HRESP=0`, `HRDATA=32'h0`.

## Timing
- Select registers: one-cycle latency, so the data phase uses the select captured in the preceding address phase.
- Slave-to-master path (`Px_HREADYOUT`/`Px_HRESP`/`Px_HRDATA` to `HREADY`/`HRESP`/`HRDATA`): purely combinational through the mux, zero added wait states.
- Unmapped valid transfer: exactly two data-phase cycles (ERR1 then ERR2), per AHB-Lite two-cycle error.
- Back-to-back unmapped transfers: the pattern repeats ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
- Slave wait states: `HREADY` follows `Px_HREADYOUT` cycle-for-cycle. The next address phase is captured on the first edge where it is 1.

## Test plan
- **Reset values:** assert `HRESET` → `HREADY=1`, `HRESP=0`, `HRDATA=0` without a clock edge.
- **Zero-wait read from RAMDATA:** NONSEQ read with `P1_HSEL=1`, then `P1_HRDATA=32'hDEADBEEF`, `P1_HREADYOUT=1` next cycle → `HRDATA=32'hDEADBEEF`, `HREADY=1`, `HRESP=0`.
- **GPIO wait states:** `P2_HREADYOUT` low 3 cycles → `HREADY` low 3 cycles. Meanwhile drive `P3_HSEL=1` on the bus; it must not be captured until `HREADY` rises.
- **Unmapped valid transfer:** all HSEL 0, `HTRANS=2'b10` → next cycles `HREADY/HRESP` = 0/1 then 1/1, then 1/0. The same stimulus with `HTRANS=2'b00` → 1/0 throughout.
- **Back-to-back unmapped:** two NONSEQ to unmapped addresses, the second presented during ERR2 → sequence 0/1, 1/1, 0/1, 1/1.
- **Disabled port and reset mid-error:**
  - With `Port4_en=0`, a NONSEQ with `P4_HSEL=1` → ERROR sequence.
  - Assert `HRESET` during ERR1 → `HREADY=1`, `HRESP=0` immediately, FSM in IDLE after release.
